// File: rtl/vga_pattern_gen.sv
// Raster timing generator with four selectable test patterns (white, colour bars,
// checkerboard, gradient). Define VGA_PATGEN_SCROLL_EN to scroll modes 2/3 one pixel per frame.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1,
    parameter int COLOR_W  = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [1:0]         MODE,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               READY,
    output logic               FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // One extra bit so sync-end bounds equal to the total still fit.
    localparam logic [HW:0] H_ACT      = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] H_SYNC_ON  = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] H_SYNC_OFF = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] V_ACT      = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] V_SYNC_ON  = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] V_SYNC_OFF = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic               POL  = (SYNC_POL != 0);
    localparam logic [COLOR_W-1:0] ONES = '1;

    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic [1:0]         mode_q;
    logic [HW:0]        h_x;
    logic [VW:0]        v_x;
    logic               frame_end;
    logic               active;
    logic               in_hsync;
    logic               in_vsync;
    logic               h_bit;
    logic               v_bit;
    logic               chk;
    logic [2:0]         bar;
    logic [2:0]         code;
    logic [COLOR_W-1:0] col;
    logic [COLOR_W-1:0] r_d;
    logic [COLOR_W-1:0] g_d;
    logic [COLOR_W-1:0] b_d;

    assign h_x       = {1'b0, h_cnt};
    assign v_x       = {1'b0, v_cnt};
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign active    = (h_x < H_ACT) && (v_x < V_ACT);
    assign in_hsync  = (h_x >= H_SYNC_ON) && (h_x < H_SYNC_OFF);
    assign in_vsync  = (v_x >= V_SYNC_ON) && (v_x < V_SYNC_OFF);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Pattern select only changes at the frame boundary so a frame is never mixed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q <= 2'd0;
        end else if (frame_end) begin
            mode_q <= MODE;
        end
    end

`ifdef VGA_PATGEN_SCROLL_EN
    logic [COLOR_W-1:0] offs;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            offs <= '0;
        end else if (frame_end) begin
            offs <= offs + 1'b1;
        end
    end

    assign col   = COLOR_W'(h_cnt) + offs;
    assign h_bit = 1'(col >> CHK_LOG2);
`else
    assign col   = COLOR_W'(h_cnt);
    assign h_bit = 1'(h_cnt >> CHK_LOG2);
`endif

    assign v_bit = 1'(v_cnt >> CHK_LOG2);
    assign chk   = h_bit ^ v_bit;

    // Bar index is the number of bar boundaries already passed; the last bar absorbs any remainder.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_x >= (HW+1)'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
    end

    assign code = 3'd7 - bar;

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            case (mode_q)
                2'd0: begin
                    r_d = ONES;
                    g_d = ONES;
                    b_d = ONES;
                end
                2'd1: begin
                    r_d = {COLOR_W{code[2]}};
                    g_d = {COLOR_W{code[1]}};
                    b_d = {COLOR_W{code[0]}};
                end
                2'd2: begin
                    r_d = {COLOR_W{chk}};
                    g_d = {COLOR_W{chk}};
                    b_d = {COLOR_W{chk}};
                end
                default: begin
                    r_d = col;
                    g_d = col;
                    b_d = col;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RED         <= '0;
            GREEN       <= '0;
            BLUE        <= '0;
            HSYNC       <= ~POL;
            VSYNC       <= ~POL;
            READY       <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            RED         <= r_d;
            GREEN       <= g_d;
            BLUE        <= b_d;
            HSYNC       <= in_hsync ? POL : ~POL;
            VSYNC       <= in_vsync ? POL : ~POL;
            READY       <= active;
            FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken raster (80x32 clocks per frame) with a
// position-based reference model, random mode changes and a mid-frame reset.
module tb_vga_pattern_gen;

    localparam int HA = 64, HF = 4, HS = 6, HB = 6;
    localparam int VA = 24, VF = 2, VS = 3, VB = 3;
    localparam int CW = 8, CHK = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [1:0]    MODE = 2'd0;
    logic [CW-1:0] RED, GREEN, BLUE;
    logic          HSYNC, VSYNC, READY, FRAME_START;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .COLOR_W(CW), .CHK_LOG2(CHK)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .READY(READY), .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: edge count since reset release gives raster position directly.
    int n = 0;
    int cur_mode = 0;
    int offs = 0;
    logic [7:0] er = 0, eg = 0, eb = 0;
    logic ehs = 0, evs = 0, erdy = 0, efs = 0;

    always @(posedge CLK or negedge RST_N) begin : model
        int p, h, v, bar, c, col, val;
        if (!RST_N) begin
            n = 0; cur_mode = 0; offs = 0;
            er = 0; eg = 0; eb = 0;
            ehs = 0; evs = 0; erdy = 0; efs = 0;
        end else begin
            p = n % FRAME;
            h = p % HT;
            v = p / HT;
            erdy = (h < HA) && (v < VA);
            ehs  = (h >= HA + HF) && (h < HA + HF + HS);
            evs  = (v >= VA + VF) && (v < VA + VF + VS);
            efs  = (p == 0);
`ifdef VGA_PATGEN_SCROLL_EN
            col = (h + offs) % 256;
`else
            col = h % 256;
`endif
            er = 0; eg = 0; eb = 0;
            if (erdy) begin
                case (cur_mode)
                    0: begin er = 8'hFF; eg = 8'hFF; eb = 8'hFF; end
                    1: begin
                        bar = h / (HA / 8);
                        if (bar > 7) bar = 7;
                        c = 7 - bar;
                        er = ((c >> 2) & 1) ? 8'hFF : 8'h00;
                        eg = ((c >> 1) & 1) ? 8'hFF : 8'h00;
                        eb = (c & 1) ? 8'hFF : 8'h00;
                    end
                    2: begin
                        val = ((col >> CHK) ^ (v >> CHK)) & 1;
                        er = val ? 8'hFF : 8'h00; eg = er; eb = er;
                    end
                    default: begin er = 8'(col); eg = 8'(col); eb = 8'(col); end
                endcase
            end
            if (p == FRAME - 1) begin
                cur_mode = int'(MODE);
                offs = (offs + 1) % 256;
            end
            n++;
        end
    end

    always @(negedge CLK) begin
        checks++;
        if ({RED, GREEN, BLUE, HSYNC, VSYNC, READY, FRAME_START} !==
            {er, eg, eb, ehs, evs, erdy, efs}) begin
            errors++;
            $display("FAIL model n=%0d actual rgb=%h/%h/%h hs=%b vs=%b rdy=%b fs=%b required rgb=%h/%h/%h hs=%b vs=%b rdy=%b fs=%b",
                     n, RED, GREEN, BLUE, HSYNC, VSYNC, READY, FRAME_START,
                     er, eg, eb, ehs, evs, erdy, efs);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_n(input int target);
        int guard = 0;
        while (n < target && guard < 100000) begin
            @(negedge CLK);
            guard++;
        end
        lit("wait_target", 32'(n), 32'(target));
    endtask

    int first_hs, second_hs, hs_w, rdy_cnt, vs_cnt, vs_first, fs_cnt;
    logic prev_hs;
    logic [7:0] exp_px;

    initial begin
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        first_hs = 0; second_hs = 0; hs_w = 0; rdy_cnt = 0;
        vs_cnt = 0; vs_first = 0; fs_cnt = 0; prev_hs = 1'b0;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge CLK);
            if (HSYNC && first_hs == 0) first_hs = n;
            if (HSYNC && !prev_hs && first_hs != 0 && n != first_hs && second_hs == 0) second_hs = n;
            if (HSYNC && n <= HT) hs_w++;
            prev_hs = HSYNC;
            if (READY) rdy_cnt++;
            if (VSYNC) begin
                vs_cnt++;
                if (vs_first == 0) vs_first = n;
            end
            if (FRAME_START) fs_cnt++;
            if (n == 800) MODE = 2'd1;
        end
        lit("hsync_first", 32'(first_hs), 32'd69);
        lit("hsync_width", 32'(hs_w), 32'd6);
        lit("hsync_period", 32'(second_hs - first_hs), 32'd80);
        lit("ready_per_frame", 32'(rdy_cnt), 32'd1536);
        lit("vsync_per_frame", 32'(vs_cnt), 32'd240);
        lit("vsync_first", 32'(vs_first), 32'd2081);
        lit("frame_start_count", 32'(fs_cnt), 32'd1);

        wait_n(FRAME + 1);
        lit("bars_px0", {8'h0, RED, GREEN, BLUE}, 32'hFFFFFF);
        lit("bars_fs", 32'(FRAME_START), 32'd1);
        wait_n(FRAME + 9);
        lit("bars_px8", {8'h0, RED, GREEN, BLUE}, 32'hFFFF00);
        wait_n(FRAME + 64);
        lit("bars_px63", {8'h0, RED, GREEN, BLUE}, 32'h000000);
        wait_n(FRAME + 10 * HT + 1);
        MODE = 2'd3;
        wait_n(FRAME + 12 * HT + 10);
        lit("bars_hold_midframe", {8'h0, RED, GREEN, BLUE}, 32'hFFFF00);

`ifdef VGA_PATGEN_SCROLL_EN
        exp_px = 8'h02;
`else
        exp_px = 8'h00;
`endif
        wait_n(2 * FRAME + 1);
        lit("grad_px0", {8'h0, RED, GREEN, BLUE}, {8'h0, exp_px, exp_px, exp_px});
        exp_px = exp_px + 8'h05;
        wait_n(2 * FRAME + 6);
        lit("grad_px5", {8'h0, RED, GREEN, BLUE}, {8'h0, exp_px, exp_px, exp_px});

        for (int f = 0; f < 10; f++) begin
            repeat ($urandom_range(FRAME - 1, 1)) @(negedge CLK);
            MODE = 2'($urandom_range(3, 0));
        end

        for (int g = 0; g < 2 * FRAME; g++) begin
            if (((n % FRAME) / HT) == 15 && ((n % FRAME) % HT) == 20) break;
            @(negedge CLK);
        end
        lit("pre_reset_ready", 32'(READY), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        lit("rst_rgb", {8'h0, RED, GREEN, BLUE}, 32'h0);
        lit("rst_ready", 32'(READY), 32'd0);
        lit("rst_fs", 32'(FRAME_START), 32'd0);
        lit("rst_hsync", 32'(HSYNC), 32'd0);
        lit("rst_vsync", 32'(VSYNC), 32'd0);
        MODE = 2'd2;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        wait_n(1);
        lit("restart_fs", 32'(FRAME_START), 32'd1);
        lit("restart_ready", 32'(READY), 32'd1);
        lit("restart_white", {8'h0, RED, GREEN, BLUE}, 32'hFFFFFF);
        wait_n(2 * FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
